noc_proc_interface: RTL and testbench

- Processor-side network interface for one node of the 2x2 mesh.
- Upstream of the mesh: buffers host send requests in a TX FIFO and serialises them onto the node's 11-bit configure port under the mesh's per-processor ready signal.
- Downstream of the mesh: captures the node's 9-bit receive-data port into an RX FIFO that the host pops.
- One instance per processor, p0..p3.

---
 rtl/noc_proc_interface.sv | 220 ++++++++++++++++++++++
 tb/tb_noc_proc_interface.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_proc_interface.sv
`default_nettype none
// ============================================================================
//  Module      : noc_proc_interface
//  Description : Processor-side network interface for one node of the 2x2
//                mesh. A TX FIFO buffers host send requests and serialises them
//                onto the 11-bit configure port under proc_ready. Rising-valid
//                words from the 9-bit receive port are captured into an RX FIFO
//                that the host pops.
//                Optional build macro NI_STATS_EN adds saturating 16-bit
//                tx_count / rx_count flit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_proc_interface #(
  parameter logic [1:0] NODE_ID  = 2'd0,
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_tx_valid,
  input  logic [1:0]  host_tx_dest,
  input  logic [7:0]  host_tx_data,
  output logic        host_tx_ready,
  output logic        host_rx_valid,
  output logic [7:0]  host_rx_data,
  input  logic        host_rx_pop,
  input  logic        proc_ready,
  output logic [10:0] p_configure,
  input  logic [8:0]  p_recieve_data,
  output logic        tx_drop,
`ifdef NI_STATS_EN
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
`endif
  output logic        rx_overflow
);

  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam logic [c_tx_aw:0] c_tx_one = 1;
  localparam logic [c_rx_aw:0] c_rx_one = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INJECT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [9:0]       r_tx_mem [TX_DEPTH];
  logic [c_tx_aw:0] r_tx_wptr;
  logic [c_tx_aw:0] r_tx_rptr;
  logic             r_tx_drop;
  logic             w_tx_empty;
  logic             w_tx_full;
  logic             w_tx_push;
  logic             w_tx_pop;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[c_tx_aw] != r_tx_rptr[c_tx_aw]) &&
                      (r_tx_wptr[c_tx_aw-1:0] == r_tx_rptr[c_tx_aw-1:0]);
  // A full FIFO still accepts when the FSM frees a slot on the same edge;
  // the pop depends only on registered state, so no path from proc_ready.
  assign w_tx_push  = host_tx_valid && (host_tx_dest != NODE_ID) &&
                      (!w_tx_full || w_tx_pop);
  assign host_tx_ready = !w_tx_full;
  assign tx_drop       = r_tx_drop;

  // TX pointers and the one-cycle reject pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_tx_one;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_tx_one;
      r_tx_drop <= host_tx_valid && !w_tx_push;
    end
  end

  // TX storage, entries packed as {data, dest}
  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[c_tx_aw-1:0]] <= {host_tx_data, host_tx_dest};
  end

  // ------------------------------------------------------------ inject FSM
  state_t      r_state;
  state_t      w_state_next;
  logic [10:0] r_pconf;
  logic [10:0] w_pconf_next;

  assign p_configure = r_pconf;

  // FSM state and configure-port register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pconf <= '0;
    end else begin
      r_state <= w_state_next;
      r_pconf <= w_pconf_next;
    end
  end

  // Next state: load head, hold until accepted, then one all-zero gap cycle
  always_comb begin
    w_state_next = r_state;
    w_pconf_next = r_pconf;
    w_tx_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_tx_empty) begin
          w_pconf_next = {r_tx_mem[r_tx_rptr[c_tx_aw-1:0]], 1'b1};
          w_tx_pop     = 1'b1;
          w_state_next = ST_INJECT;
        end
      end
      ST_INJECT: begin
        if (proc_ready) begin
          w_pconf_next = '0;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_pconf_next = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_pconf_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [c_rx_aw:0] r_rx_wptr;
  logic [c_rx_aw:0] r_rx_rptr;
  logic [c_rx_aw:0] w_rx_wptr_next;
  logic [c_rx_aw:0] w_rx_rptr_next;
  logic [7:0]       r_rx_head;
  logic [7:0]       w_rx_head_next;
  logic             r_rx_valid_q;
  logic             r_rx_ovf;
  logic             w_rx_empty;
  logic             w_rx_full;
  logic             w_rx_rise;
  logic             w_rx_pop;
  logic             w_rx_push;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[c_rx_aw] != r_rx_rptr[c_rx_aw]) &&
                      (r_rx_wptr[c_rx_aw-1:0] == r_rx_rptr[c_rx_aw-1:0]);
  // The mesh may hold a word for several cycles; capture only its first one
  assign w_rx_rise  = p_recieve_data[0] && !r_rx_valid_q;
  assign w_rx_pop   = host_rx_pop && !w_rx_empty;
  assign w_rx_push  = w_rx_rise && (!w_rx_full || w_rx_pop);
  assign w_rx_wptr_next = w_rx_push ? r_rx_wptr + c_rx_one : r_rx_wptr;
  assign w_rx_rptr_next = w_rx_pop  ? r_rx_rptr + c_rx_one : r_rx_rptr;

  assign host_rx_valid = !w_rx_empty;
  assign host_rx_data  = r_rx_head;
  assign rx_overflow   = r_rx_ovf;

  // Head after this edge: bypass the incoming word when it lands in the read slot
  always_comb begin
    w_rx_head_next = r_rx_mem[w_rx_rptr_next[c_rx_aw-1:0]];
    if (w_rx_push && (w_rx_rptr_next == r_rx_wptr)) begin
      w_rx_head_next = p_recieve_data[8:1];
    end else if (w_rx_rptr_next == w_rx_wptr_next) begin
      w_rx_head_next = '0;
    end
  end

  // RX pointers, registered head, edge detector and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_wptr    <= '0;
      r_rx_rptr    <= '0;
      r_rx_head    <= '0;
      r_rx_valid_q <= 1'b0;
      r_rx_ovf     <= 1'b0;
    end else begin
      r_rx_wptr    <= w_rx_wptr_next;
      r_rx_rptr    <= w_rx_rptr_next;
      r_rx_head    <= w_rx_head_next;
      r_rx_valid_q <= p_recieve_data[0];
      if (w_rx_rise && !w_rx_push) r_rx_ovf <= 1'b1;
    end
  end

  // RX storage
  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[c_rx_aw-1:0]] <= p_recieve_data[8:1];
  end

`ifdef NI_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;

  // Saturating flit counters: accepted injects and stored receives
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if ((r_state == ST_INJECT) && proc_ready && (r_tx_count != 16'hFFFF))
        r_tx_count <= r_tx_count + 16'd1;
      if (w_rx_push && (r_rx_count != 16'hFFFF))
        r_rx_count <= r_rx_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_proc_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_proc_interface
//  Description : Directed vector table plus hand sequences for back-pressure,
//                RX overflow and asynchronous reset during an inject.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_proc_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        host_tx_valid;
  logic [1:0]  host_tx_dest;
  logic [7:0]  host_tx_data;
  logic        host_tx_ready;
  logic        host_rx_valid;
  logic [7:0]  host_rx_data;
  logic        host_rx_pop;
  logic        proc_ready;
  logic [10:0] p_configure;
  logic [8:0]  p_recieve_data;
  logic        tx_drop;
  logic        rx_overflow;
`ifdef NI_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
`endif

  noc_proc_interface #(.NODE_ID(2'd0), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .host_tx_valid  (host_tx_valid),
    .host_tx_dest   (host_tx_dest),
    .host_tx_data   (host_tx_data),
    .host_tx_ready  (host_tx_ready),
    .host_rx_valid  (host_rx_valid),
    .host_rx_data   (host_rx_data),
    .host_rx_pop    (host_rx_pop),
    .proc_ready     (proc_ready),
    .p_configure    (p_configure),
    .p_recieve_data (p_recieve_data),
    .tx_drop        (tx_drop),
`ifdef NI_STATS_EN
    .tx_count       (tx_count),
    .rx_count       (rx_count),
`endif
    .rx_overflow    (rx_overflow)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        tv;
    logic [1:0]  dest;
    logic [7:0]  data;
    logic        pr;
    logic [8:0]  rx;
    logic        pop;
    logic [10:0] e_pconf;
    logic        e_txr;
    logic        e_rxv;
    logic [7:0]  e_rxd;
    logic        e_drop;
    logic        e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic tv, input logic [1:0] dest, input logic [7:0] data,
                              input logic pr, input logic [8:0] rx, input logic pop,
                              input logic [10:0] e_pconf, input logic e_txr, input logic e_rxv,
                              input logic [7:0] e_rxd, input logic e_drop, input logic e_ovf);
    vec_t v;
    v.tv = tv; v.dest = dest; v.data = data; v.pr = pr; v.rx = rx; v.pop = pop;
    v.e_pconf = e_pconf; v.e_txr = e_txr; v.e_rxv = e_rxv; v.e_rxd = e_rxd;
    v.e_drop = e_drop; v.e_ovf = e_ovf;
    return v;
  endfunction

  vec_t vt[12];

  initial begin
    logic [7:0]  d;
    logic [10:0] e;
    logic        prev_valid;
    int          n;

    // single flit dest=2 data=01, dest==NODE_ID reject, held RX word then pops
    vt[0]  = mk(1'b1, 2'd2, 8'h01, 1'b1, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 9'h000, 1'b0, 11'h00D, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[2]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, 2'd0, 8'hAA, 1'b0, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    vt[6]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h000, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h003, 1'b0, 11'h000, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    vt[8]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h003, 1'b0, 11'h000, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    vt[9]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h003, 1'b0, 11'h000, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    vt[10] = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h000, 1'b1, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[11] = mk(1'b0, 2'd0, 8'h00, 1'b0, 9'h000, 1'b1, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    host_tx_valid = 1'b0; host_tx_dest = 2'd0; host_tx_data = 8'h00;
    host_rx_pop = 1'b0; proc_ready = 1'b0; p_recieve_data = 9'h000;
    reset = 1'b0;
    #12;
    chk("rst_pconf", 32'(p_configure), 32'h000);
    chk("rst_txr",   32'(host_tx_ready), 32'h1);
    chk("rst_rxv",   32'(host_rx_valid), 32'h0);
    chk("rst_rxd",   32'(host_rx_data), 32'h00);
    chk("rst_drop",  32'(tx_drop), 32'h0);
    chk("rst_ovf",   32'(rx_overflow), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("idle_pconf", 32'(p_configure), 32'h000);
    chk("idle_txr",   32'(host_tx_ready), 32'h1);

    // ------------------------------------------------ vector table
    for (int i = 0; i < 12; i++) begin
      host_tx_valid = vt[i].tv; host_tx_dest = vt[i].dest; host_tx_data = vt[i].data;
      proc_ready = vt[i].pr; p_recieve_data = vt[i].rx; host_rx_pop = vt[i].pop;
      step();
      chk($sformatf("v%0d_pconf", i), 32'(p_configure), 32'(vt[i].e_pconf));
      chk($sformatf("v%0d_txr", i),   32'(host_tx_ready), 32'(vt[i].e_txr));
      chk($sformatf("v%0d_rxv", i),   32'(host_rx_valid), 32'(vt[i].e_rxv));
      if (vt[i].e_rxv) chk($sformatf("v%0d_rxd", i), 32'(host_rx_data), 32'(vt[i].e_rxd));
      chk($sformatf("v%0d_drop", i),  32'(tx_drop), 32'(vt[i].e_drop));
      chk($sformatf("v%0d_ovf", i),   32'(rx_overflow), 32'(vt[i].e_ovf));
    end
    host_rx_pop = 1'b0;

    // ------------------------------------------------ back-pressure
    // One flit moves into the configure register, so the FIFO fills on the 5th
    // push and the 6th is rejected.
    proc_ready = 1'b0;
    host_tx_valid = 1'b1;
    host_tx_dest = 2'd1;
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      host_tx_data = d;
      step();
      chk($sformatf("bp_drop%0d", i), 32'(tx_drop), (i == 5) ? 32'h1 : 32'h0);
      if (i >= 4) chk($sformatf("bp_txr%0d", i), 32'(host_tx_ready), 32'h0);
    end
    host_tx_valid = 1'b0;
    chk("bp_head", 32'(p_configure), 32'h083);
    step(); step(); step();
    chk("bp_hold", 32'(p_configure), 32'h083);
    proc_ready = 1'b1;
    prev_valid = 1'b1;
    n = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (p_configure[0]) begin
        d = 8'h10 + 8'(n);
        e = {d, 2'd1, 1'b1};
        chk($sformatf("bp_gap%0d", n), 32'(prev_valid), 32'h0);
        chk($sformatf("bp_flit%0d", n), 32'(p_configure), 32'(e));
        n++;
      end else begin
        chk("bp_idle_zero", 32'(p_configure), 32'h000);
      end
      prev_valid = p_configure[0];
    end
    chk("bp_count", 32'(n), 32'd5);
    chk("bp_txr_end", 32'(host_tx_ready), 32'h1);

    // ------------------------------------------------ RX overflow
    for (int i = 0; i < 5; i++) begin
      d = 8'hA0 + 8'(i);
      p_recieve_data = {d, 1'b1};
      step();
      p_recieve_data = 9'h000;
      step();
      if (i == 3) chk("ovf_before", 32'(rx_overflow), 32'h0);
    end
    chk("ovf_set", 32'(rx_overflow), 32'h1);
    chk("ovf_rxv", 32'(host_rx_valid), 32'h1);
    chk("ovf_head0", 32'(host_rx_data), 32'hA0);
    host_rx_pop = 1'b1;
    step();
    chk("ovf_head1", 32'(host_rx_data), 32'hA1);
    step();
    chk("ovf_head2", 32'(host_rx_data), 32'hA2);
    host_rx_pop = 1'b0;
    step();
    chk("ovf_sticky", 32'(rx_overflow), 32'h1);

    // ------------------------------------------------ reset during inject
    proc_ready = 1'b0;
    host_tx_valid = 1'b1; host_tx_dest = 2'd3; host_tx_data = 8'h55;
    step();
    host_tx_data = 8'h56;
    step();
    host_tx_valid = 1'b0;
    chk("mid_pconf", 32'(p_configure), 32'h2AF);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pconf", 32'(p_configure), 32'h000);
    chk("arst_txr",   32'(host_tx_ready), 32'h1);
    chk("arst_rxv",   32'(host_rx_valid), 32'h0);
    chk("arst_ovf",   32'(rx_overflow), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    proc_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post_rst_pconf%0d", c), 32'(p_configure), 32'h000);
      chk($sformatf("post_rst_rxv%0d", c), 32'(host_rx_valid), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
